// File: rtl/handshake_tx_ctrl_pkg.sv
// Shared types and default sizing for the handshake transmit sequencer.
//   hs_tx_state_t : sequencer FSM states
//   HS_WIDTH / HS_DEPTH / HS_TIMEOUT : default parameter values
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO
  } hs_tx_state_t;

  localparam int HS_WIDTH   = 32;
  localparam int HS_DEPTH   = 4;
  localparam int HS_TIMEOUT = 256;

endpackage

// File: rtl/handshake_tx_ctrl_if.sv
// Producer and handshake-side bus of the transmit sequencer.
//   in_valid/in_ready/in_data : producer valid/ready word stream
//   start                     : one-cycle launch pulse to the handshake
//   xfer_data                 : word held stable for the handshake
//   done                      : handshake completion level (clk domain)
// slave  : the sequencer side
// master : the producer/handshake side
interface handshake_tx_ctrl_if import hs_pkg::*; #(
  parameter int WIDTH = HS_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             start;
  logic [WIDTH-1:0] xfer_data;
  logic             done;

  modport slave (
    input  in_valid, in_data, done,
    output in_ready, start, xfer_data
  );

  modport master (
    output in_valid, in_data, done,
    input  in_ready, start, xfer_data
  );
endinterface

// File: rtl/handshake_tx_ctrl_fifo.sv
// Single-clock FIFO with registered occupancy and a combinational head read.
//   clk, rst_n  : clock, synchronous active-low reset (drops all entries)
//   push, wdata : write request (ignored when full)
//   pop         : release head (ignored when empty)
//   full, empty : registered status
//   level       : occupancy, 0..DEPTH
//   head        : oldest entry, 0 when empty
module sync_fifo import hs_pkg::*; #(
  parameter int WIDTH = HS_WIDTH,
  parameter int DEPTH = HS_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] head
);

  // Extra MSB on each pointer separates full from empty after a wrap.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          level <= level + 1'b1;
          full  <= (level == (AW+1)'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - 1'b1;
          full  <= 1'b0;
          empty <= (level == (AW+1)'(1));
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing is read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/handshake_tx_ctrl.sv
// Write-domain sequencer in front of the handshake CDC block. Buffers producer
// words, presents the head word, fires start, follows done high then low and
// pops the word. A per-transfer timeout drops a stuck word and raises a
// sticky error.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : producer stream + start/xfer_data/done (slave modport)
//   busy        : FSM not in IDLE
//   level       : FIFO occupancy
//   timeout_err : sticky abort flag, cleared by err_clr
module handshake_tx_ctrl import hs_pkg::*; #(
  parameter int WIDTH   = HS_WIDTH,
  parameter int DEPTH   = HS_DEPTH,
  parameter int TIMEOUT = HS_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  handshake_tx_ctrl_if.slave     bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  hs_tx_state_t    state, nxt;
  logic [CW-1:0]   cnt;
  logic            full, empty, pop, abort, launch, at_limit;
  logic [WIDTH-1:0] head;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .wdata (bus.in_data),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  assign bus.in_ready  = !full;
  assign bus.xfer_data = head;
  assign bus.start     = launch;
  assign busy          = (state != IDLE);
  assign at_limit      = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LAUNCH)
        cnt <= '0;
      else if (state == WAIT_HI || state == WAIT_LO)
        cnt <= cnt + CW'(1);
      // A new abort outranks a simultaneous clear.
      if (abort)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

  always_comb begin
    nxt    = state;
    launch = 1'b0;
    pop    = 1'b0;
    abort  = 1'b0;
    case (state)
      IDLE:    if (!empty) nxt = LAUNCH;
      LAUNCH: begin
        launch = 1'b1;
        nxt    = WAIT_HI;
      end
      WAIT_HI: begin
        if (at_limit) begin
          pop   = 1'b1;
          abort = 1'b1;
          nxt   = IDLE;
        end else if (bus.done) begin
          nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // done falling on the limit cycle still counts as a completion.
        if (!bus.done) begin
          pop = 1'b1;
          nxt = IDLE;
        end else if (at_limit) begin
          pop   = 1'b1;
          abort = 1'b1;
          nxt   = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
module tb_handshake_tx_ctrl;
  import hs_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [2:0] level;
  logic       timeout_err;
  logic       err_clr;
  logic       done_m, done_force;
  int         hs_mode;   // 0 auto, 1 stall until released, 2 never answer
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         starts   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  handshake_tx_ctrl_if #(.WIDTH(32)) bus ();
  assign bus.done = done_m | done_force;

  handshake_tx_ctrl #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_word(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_wait", 32'(n < 200), 1);
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 600 && !(busy == 1'b0 && level == 3'd0)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < 600), 1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (bus.start !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, bus.start, 1);
  endtask

  // Handshake model: done rises 3 cycles after start, falls 4 cycles later.
  initial begin : done_model
    done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1 && hs_mode != 2) begin
        for (int i = 0; i < 100 && hs_mode == 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        done_m = 1'b1;
        repeat (4) @(negedge clk);
        done_m = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every start must present the next expected word,
  // and that word must hold until busy drops.
  initial begin : monitor
    logic [31:0] held, exp;
    bit changed, prev_busy;
    held = '0; changed = 0; prev_busy = 0;
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1) begin
        starts++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_start: got start with xfer_data %0h expected no start", bus.xfer_data);
        end else begin
          exp = exp_q.pop_front();
          check("xfer_data_at_start", bus.xfer_data, exp);
        end
        held    = bus.xfer_data;
        changed = 0;
      end else if (busy === 1'b1 && bus.xfer_data !== held) begin
        changed = 1;
      end
      if (prev_busy && busy === 1'b0) check("xfer_stable", 32'(changed), 0);
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin : stim
    int n;
    int s0;
    rst_n = 1'b0; err_clr = 1'b0; hs_mode = 0; done_force = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_start", bus.start, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_xfer_data", bus.xfer_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    push_word(32'hA5A5_0001);
    @(negedge clk); #1;
    check("single_no_start_yet", bus.start, 0);
    check("single_idle_busy", busy, 0);
    @(negedge clk); #1;
    check("single_start_hi", bus.start, 1);
    check("single_busy", busy, 1);
    @(negedge clk); #1;
    check("single_start_one_cycle", bus.start, 0);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("single_done_rise", bus.done, 1);
    n = 0;
    while (bus.done !== 1'b0 && n < 50) begin @(negedge clk); #1; n++; end
    check("single_done_fall", bus.done, 0);
    check("single_level_before_pop", level, 1);
    @(posedge clk); #1;
    check("single_level_after_pop", level, 0);
    check("single_busy_after", busy, 0);

    // Fill and wrap with a stalled handshake
    hs_mode = 1;
    fork
      for (int i = 1; i <= 6; i++) push_word(32'(i));
    join_none
    n = 0;
    while (level != 3'd4 && n < 50) begin @(negedge clk); #1; n++; end
    check("fill_level_full", level, 4);
    check("fill_in_ready_low", bus.in_ready, 0);
    hs_mode = 0;
    n = 0;
    while (level != 3'd3 && n < 50) begin @(negedge clk); #1; n++; end
    check("fill_level_after_pop", level, 3);
    check("fill_in_ready_back", bus.in_ready, 1);
    wait fork;
    wait_idle("fill_drain");
    check("fill_all_delivered", exp_q.size(), 0);

    // Timeout: done never answers, second word launches normally
    hs_mode = 2;
    push_word(32'h0000_0077);
    push_word(32'h0000_0088);
    wait_start("to_start");
    @(posedge clk);              // enters WAIT_HI
    repeat (15) @(posedge clk);
    #1;
    check("to_no_err_early", timeout_err, 0);
    check("to_level_before", level, 2);
    @(posedge clk); #1;
    check("to_err_set", timeout_err, 1);
    check("to_word_dropped", level, 1);
    check("to_idle", busy, 0);
    hs_mode = 0;
    wait_idle("to_next_word");
    check("to_err_sticky", timeout_err, 1);

    // err_clr alone, then err_clr on the abort cycle
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_alone", timeout_err, 0);
    hs_mode = 2;
    push_word(32'h0000_0099);
    wait_start("clr_start");
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_vs_timeout_set_wins", timeout_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_alone_again", timeout_err, 0);
    hs_mode = 0;

    // Reset in WAIT_LO with three words queued behind the head
    for (int i = 0; i < 4; i++) push_word(32'h31 + 32'(i));
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("mid_done_rise", bus.done, 1);
    @(negedge clk); #1;
    check("mid_level_before", level, 4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_level", level, 0);
    check("mid_start", bus.start, 0);
    check("mid_busy", busy, 0);
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_xfer_data", bus.xfer_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    repeat (15) @(negedge clk);
    #1;
    check("mid_no_start_after", starts - s0, 0);
    check("mid_still_idle", busy, 0);

    // Spurious done in IDLE with empty FIFO
    s0 = starts;
    done_force = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("spur_busy", busy, 0);
      check("spur_start", bus.start, 0);
    end
    done_force = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("spur_no_start", starts - s0, 0);
    check("spur_level", level, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
